// File: rtl/ru_mem_arbiter_pkg.sv
// ru_mem_pkg: shared types for the memory arbiter.
//   arb_state_t         - arbiter FSM states
//   arb_port_t          - requester identity (instruction fetch / load-store)
//   ARB_TIMEOUT_DEFAULT - default busy-cycle limit before an error ack
//   is_misaligned()     - word-alignment test on the two address LSBs
package ru_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

    localparam int ARB_TIMEOUT_DEFAULT = 16;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ru_mem_arbiter_if.sv
// ru_mem_arbiter_if: bundles the fetch port (i_*), load/store port (d_*),
// the shared error flag and the single-ported RAM port (ram_*).
//   slave  - arbiter view: takes requests and RAM responses, drives acks,
//            read data, err and the RAM command
//   master - environment view (requesters + RAM model), the mirror image
interface ru_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              err;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata, ram_busy,
        output i_rdata, i_ack, d_rdata, d_ack, err, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata, ram_busy,
        input  i_rdata, i_ack, d_rdata, d_ack, err, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ru_mem_arbiter_pick.sv
// ru_arb_pick: combinational two-way grant selection.
//   i_req, d_req - pending requests
//   last_win     - port granted most recently
//   rr_en        - 1: round-robin on contention, 0: D has fixed priority
//   grant        - selected port (only meaningful when a request is pending)
module ru_arb_pick
    import ru_mem_pkg::*;
(
    input  logic      i_req,
    input  logic      d_req,
    input  arb_port_t last_win,
    input  logic      rr_en,
    output arb_port_t grant
);
    always_comb begin
        grant = PORT_I;
        if (i_req && d_req) begin
            // On contention the loser of the previous round wins; without
            // round-robin, loads/stores drain ahead of the next fetch.
            grant = (rr_en && last_win == PORT_D) ? PORT_I : PORT_D;
        end else if (d_req) begin
            grant = PORT_D;
        end
    end
endmodule

// File: rtl/ru_mem_arbiter.sv
// ru_mem_arbiter: shares one single-ported word RAM between the fetch port
// (read-only) and the load/store port. One request is latched at a time,
// the RAM is driven from the latched request until ram_busy clears, and a
// one-cycle ack returns the read data. Misaligned and timed-out accesses
// complete with err=1 and zero data.
//   clk, rst - clock and synchronous active-high reset
//   bus      - ru_mem_arbiter_if.slave: i_* fetch port, d_* load/store port,
//              err, ram_* RAM command/response
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration on
// simultaneous requests; otherwise D always beats I.
module ru_mem_arbiter
    import ru_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT
) (
    input logic             clk,
    input logic             rst,
    ru_mem_arbiter_if.slave bus
);
`ifdef ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    arb_state_t        state, state_nxt;
    arb_port_t         grant, last_win, lat_id;
    logic              lat_we, lat_mis;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  cnt;

    logic              ram_we_q, i_ack_q, d_ack_q, err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ram_we_nxt, i_ack_nxt, d_ack_nxt, err_nxt;
    logic [DATA_W-1:0] rdata_nxt;

    logic              any_req, win_we, win_mis, timeout_hit;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    ru_arb_pick u_pick (
        .i_req    (bus.i_req),
        .d_req    (bus.d_req),
        .last_win (last_win),
        .rr_en    (RR_EN),
        .grant    (grant)
    );

    assign any_req   = bus.i_req | bus.d_req;
    assign win_addr  = (grant == PORT_D) ? bus.d_addr : bus.i_addr;
    assign win_wdata = (grant == PORT_D) ? bus.d_wdata : '0;
    assign win_we    = (grant == PORT_D) && bus.d_we;
    assign win_mis   = is_misaligned(win_addr[1:0]);
    // Fires on the TIMEOUT_CYC-th consecutive busy cycle of an access.
    assign timeout_hit = bus.ram_busy && (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:   if (any_req) state_nxt = ARB_ACCESS;
            // A misaligned winner spends one dead cycle here with the RAM
            // untouched, so every ack keeps the same two-cycle latency.
            ARB_ACCESS: if (lat_mis || !bus.ram_busy || timeout_hit) state_nxt = ARB_RESP;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    // Next values for the registered outputs.
    always_comb begin
        ram_we_nxt = 1'b0;
        i_ack_nxt  = 1'b0;
        d_ack_nxt  = 1'b0;
        err_nxt    = 1'b0;
        rdata_nxt  = '0;
        case (state)
            ARB_IDLE: ram_we_nxt = any_req && win_we && !win_mis;
            ARB_ACCESS: begin
                if (state_nxt == ARB_ACCESS) begin
                    ram_we_nxt = lat_we;
                end else begin
                    i_ack_nxt = (lat_id == PORT_I);
                    d_ack_nxt = (lat_id == PORT_D);
                    err_nxt   = lat_mis || timeout_hit;
                    rdata_nxt = (lat_we || err_nxt) ? '0 : bus.ram_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_id    <= PORT_I;
            lat_we    <= 1'b0;
            lat_mis   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            last_win  <= PORT_I;
            cnt       <= '0;
            ram_we_q  <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ram_we_q <= ram_we_nxt;
            i_ack_q  <= i_ack_nxt;
            d_ack_q  <= d_ack_nxt;
            err_q    <= err_nxt;
            rdata_q  <= rdata_nxt;
            if (state == ARB_IDLE && any_req) begin
                lat_id    <= grant;
                lat_we    <= win_we && !win_mis;
                lat_mis   <= win_mis;
                lat_addr  <= win_addr;
                lat_wdata <= win_wdata;
                last_win  <= grant;
                cnt       <= '0;
            end else if (state == ARB_ACCESS && bus.ram_busy) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = lat_addr;
    assign bus.ram_wdata = lat_wdata;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.err       = err_q;
    assign bus.i_rdata   = rdata_q;
    assign bus.d_rdata   = rdata_q;
endmodule

// File: tb/tb_ru_mem_arbiter.sv
// tb_ru_mem_arbiter: directed bench for ru_mem_arbiter with a small word RAM
// model and a scoreboard of expected acks drained by a negedge monitor.
module tb_ru_mem_arbiter;
    logic clk;
    logic rst;

    ru_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ru_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   we_total = 0;
    bit   mem_loaded;
    logic [31:0] mem [0:63];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.ram_we) we_total <= we_total + 1;

    // RAM model: combinational read, write on an edge with ram_we and not busy.
    assign bus.ram_rdata = mem[bus.ram_addr[7:2]];
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
            mem[2] <= 32'hDEADBEEF;
            mem[3] <= 32'h0000C00C;
            mem[4] <= 32'hA5A50004;
            mem[5] <= 32'h5A5A0005;
            mem_loaded <= 1'b1;
        end else if (bus.ram_we && !bus.ram_busy) begin
            mem[bus.ram_addr[7:2]] <= bus.ram_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // lat < 0: ack cycle not checked (contention ordering tests).
    task automatic expect_ack(input bit is_d, input logic [31:0] rd, input logic er, input int lat);
        exp_t e;
        e.is_d  = is_d;
        e.rdata = rd;
        e.err   = er;
        e.cyc   = (lat < 0) ? -1 : cyc + lat;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input bit is_d);
        bit got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            got = is_d ? bus.d_ack : bus.i_ack;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL ack_timeout: port %s got no ack within 60 cycles, ack required", is_d ? "D" : "I");
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the IDLE cycle after ack.
    task automatic access(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        wait_ack(is_d);
        @(posedge clk); #1;
        if (is_d) bus.d_req = 1'b0;
        else      bus.i_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.i_ack || bus.d_ack) begin
                chk("one_ack", 32'(bus.i_ack & bus.d_ack), 32'h0);
                chk("we_low_at_ack", 32'(bus.ram_we), 32'h0);
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_ack: i_ack=%0b d_ack=%0b, no transaction outstanding", bus.i_ack, bus.d_ack);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_port", 32'(bus.d_ack), 32'(mon_e.is_d));
                    chk("rdata", bus.d_ack ? bus.d_rdata : bus.i_rdata, mon_e.rdata);
                    chk("err", 32'(bus.err), 32'(mon_e.err));
                    if (mon_e.cyc >= 0) chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end else begin
                chk("err_without_ack", 32'(bus.err), 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        int w0;
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.ram_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_i_ack", 32'(bus.i_ack), 32'h0);
        chk("rst_d_ack", 32'(bus.d_ack), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'h0);
        chk("rst_ram_addr", bus.ram_addr, 32'h0);
        chk("rst_ram_wdata", bus.ram_wdata, 32'h0);
        chk("rst_rdata", bus.i_rdata | bus.d_rdata, 32'h0);
        rst = 1'b0;

        // Fetch, no busy: ack two cycles after the request is seen in IDLE.
        expect_ack(1'b0, 32'hDEADBEEF, 1'b0, 2);
        access(1'b0, 1'b0, 32'h8, 32'h0);

        // Store, then read back.
        w0 = we_total;
        expect_ack(1'b1, 32'h0, 1'b0, 2);
        access(1'b1, 1'b1, 32'h4, 32'h1234);
        chk("store_we_cycles", 32'(we_total - w0), 32'd1);
        expect_ack(1'b1, 32'h1234, 1'b0, 2);
        access(1'b1, 1'b0, 32'h4, 32'h0);

        // Misaligned store and fetch: error ack, RAM never written.
        w0 = we_total;
        expect_ack(1'b1, 32'h0, 1'b1, 2);
        access(1'b1, 1'b1, 32'h6, 32'hFFFF);
        chk("misaligned_we_cycles", 32'(we_total - w0), 32'd0);
        expect_ack(1'b0, 32'h0, 1'b1, 2);
        access(1'b0, 1'b0, 32'h2, 32'h0);
        expect_ack(1'b1, 32'h1234, 1'b0, 2);
        access(1'b1, 1'b0, 32'h4, 32'h0);

        // Busy for three ACCESS cycles: ack at +5.
        expect_ack(1'b0, 32'hDEADBEEF, 1'b0, 5);
        bus.ram_busy = 1'b1;
        fork
            begin
                repeat (4) @(posedge clk);
                #1 bus.ram_busy = 1'b0;
            end
            access(1'b0, 1'b0, 32'h8, 32'h0);
        join

        // Busy stuck: error ack on the 16th busy cycle, store never lands.
        bus.ram_busy = 1'b1;
        expect_ack(1'b1, 32'h0, 1'b1, 17);
        access(1'b1, 1'b0, 32'h10, 32'h0);
        w0 = we_total;
        expect_ack(1'b1, 32'h0, 1'b1, 17);
        access(1'b1, 1'b1, 32'h18, 32'h00000BAD);
        chk("timeout_store_we_cycles", 32'(we_total - w0), 32'd16);
        bus.ram_busy = 1'b0;
        expect_ack(1'b1, 32'h0, 1'b0, 2);
        access(1'b1, 1'b0, 32'h18, 32'h0);

        // Contention: reset first so the last winner starts as I.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        expect_ack(1'b1, 32'hA5A50004, 1'b0, -1);
        expect_ack(1'b0, 32'hDEADBEEF, 1'b0, -1);
        expect_ack(1'b1, 32'h5A5A0005, 1'b0, -1);
        expect_ack(1'b0, 32'h0000C00C, 1'b0, -1);
`else
        expect_ack(1'b1, 32'hA5A50004, 1'b0, -1);
        expect_ack(1'b1, 32'h5A5A0005, 1'b0, -1);
        expect_ack(1'b0, 32'hDEADBEEF, 1'b0, -1);
        expect_ack(1'b0, 32'h0000C00C, 1'b0, -1);
`endif
        fork
            begin
                bus.i_req = 1'b1; bus.i_addr = 32'h8;
                wait_ack(1'b0);
                @(posedge clk); #1 bus.i_addr = 32'hC;
                wait_ack(1'b0);
                @(posedge clk); #1 bus.i_req = 1'b0;
            end
            begin
                bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
                wait_ack(1'b1);
                @(posedge clk); #1 bus.d_addr = 32'h14;
                wait_ack(1'b1);
                @(posedge clk); #1 bus.d_req = 1'b0;
            end
        join

        // Reset during ACCESS: no ack, outputs cleared on the next cycle.
        bus.ram_busy = 1'b1;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h77;
        @(posedge clk); #1;
        chk("we_in_access", 32'(bus.ram_we), 32'h1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_ram_we", 32'(bus.ram_we), 32'h0);
        chk("abort_d_ack", 32'(bus.d_ack), 32'h0);
        chk("abort_ram_addr", bus.ram_addr, 32'h0);
        bus.d_req = 1'b0;
        bus.ram_busy = 1'b0;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
